mvm_ctrl: RTL and testbench
===========================

MVM_CTRL -- requirements
Module: mvm_ctrl

Interface
REQ-001 Parameter K, default 8, matrix dimension: KxK matrix, K-element vector.
REQ-002 Parameter B, default 8, input word width in bits; results are 2*B bits.
REQ-003 Parameter NREQ, default 2, number of requesters, range 2..4.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low (asserted when 0).
REQ-006 req  in  NREQ  per-requester job request, held until the job's grant.
REQ-007 req_reuse  in  NREQ  per-requester "matrix unchanged, skip reload" hint.
REQ-008 gnt  out  NREQ  one-hot grant, held for the whole job.
REQ-009 in_valid  in  NREQ  per-requester input word valid.
REQ-010 in_data  in  NREQ*B  per-requester signed input word, packed; slice i belongs to requester i.
REQ-011 in_ready  out  NREQ  the word from the granted requester is consumed this cycle.
REQ-012 out_valid  out  NREQ  result word valid for requester i.
REQ-013 out_data  out  2*B  signed result word, shared by all requesters.
REQ-014 out_last  out  1  marks the K-th result word.
REQ-015 err  out  NREQ  one-cycle pulse: the job of requester i was aborted.
REQ-016 core_loadMatrix, core_loadVector, core_start  out  1 each  one-cycle command pulses to the MVM core.
REQ-017 core_data_in  out  B  word to the core.
REQ-018 core_done  in  1  core completion pulse.
REQ-019 core_data_out  in  2*B  core result word.

Function
REQ-020 Core protocol: after a load pulse, the core takes one word per cycle on the K*K (matrix) or K (vector) cycles that immediately follow. After core_done, results are valid on the K cycles that immediately follow.
REQ-021 States: IDLE, LOAD_M, LOAD_V, START, WAIT, DRAIN.
- IDLE: when any req is high, the controller grants the next requester in round-robin order after the last granted one, with gnt registered.
- After the grant, the state goes to LOAD_M, or to LOAD_V when reuse applies (see Configuration).
REQ-022 Load entry: the load pulse is issued in the first cycle that the granted requester's in_valid is high. That word is not consumed. The K*K (or K) words that follow are consumed one per cycle, with in_ready high.
REQ-023 Streaming: in_valid must stay high during the load.
- If in_valid is low while a word is due: err[i] pulses, gnt drops, and the state returns to IDLE.
- The stored matrix is then marked invalid.
REQ-024 Transitions:
- LOAD_M completes into LOAD_V.
- LOAD_V completes into START, which drives core_start for one cycle.
- START goes to WAIT.
- WAIT goes to DRAIN on core_done.
REQ-025 DRAIN: for K cycles, out_valid[i] is high and out_data equals core_data_out; out_last is high on the last cycle. The following cycle, gnt drops and the state returns to IDLE. There is no output backpressure.
REQ-026 WAIT timeout: if core_done has not arrived 4*K*K cycles after core_start, err[i] pulses, the matrix is marked invalid, and the state returns to IDLE.
REQ-027 Deasserting req during a job has no effect; the job completes. A new grant is possible at the earliest one cycle after DRAIN ends.
REQ-028 Outputs that are not driven by the current state are 0. core_data_in equals the granted requester's in_data slice.

Reset
REQ-029 While reset is asserted:
- state is IDLE;
- gnt, in_ready, out_valid, out_last, err and the core pulses are 0;
- out_data and core_data_in are 0;
- the round-robin pointer points at requester 0, so requester 0 has highest priority first;
- the matrix is marked invalid.
REQ-030 When reset is asserted mid-job, all of these outputs clear asynchronously; no err pulse is issued.

Configuration
REQ-031 Macro MVM_CTRL_MATRIX_REUSE_EN.
- Defined: when req_reuse[i] is high at grant, the matrix is valid, and i owned the last completed load, LOAD_M is skipped.
- Undefined: req_reuse is ignored and LOAD_M always runs.

Structure
REQ-032 Package mvm_ctrl_pkg holds the state enum type and the timeout multiplier constant (4).
REQ-033 The round-robin arbiter is the sub-module rr_arb.
- Inputs: req and an advance enable.
- Output: one-hot gnt.

Verification
REQ-034 Req0 only, K=8, streamed ramp with A=1..64 and x all 1:
- core_loadMatrix pulses once, then 64 words are consumed, then core_loadVector pulses, then 8 words are consumed;
- 8 out_valid[0] cycles follow core_done, with out_last on the 8th.
REQ-035 req0 and req1 held high continuously: grants alternate 0,1,0,1, and no cycle has both gnt bits high.
REQ-036 in_valid[1] dropped at LOAD_M word 30: err[1] pulses once, the state returns to IDLE, and no core_start is issued.
REQ-037 core_done withheld: err pulses exactly 256 cycles after core_start.
REQ-038 With the macro defined, a second req0 job with req_reuse=1 gives no core_loadMatrix, only a vector load. Without the macro, the same job still gives a core_loadMatrix.
REQ-039 Reset asserted during DRAIN: all outputs are 0 immediately. After release, the next req1 job is granted and completes normally.

Source files
------------

// File: rtl/mvm_ctrl_pkg.sv
// rtl/mvm_ctrl_pkg.sv - shared state encoding and timing constants for the MVM controller
package mvm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_M,
    ST_LOAD_V,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  // Core completion must arrive within TMO_MULT*K*K cycles of core_start.
  localparam int TMO_MULT = 4;

endpackage

// File: rtl/mvm_ctrl_if.sv
// rtl/mvm_ctrl_if.sv - requester and core bundle between the testbench/system and mvm_ctrl
interface mvm_ctrl_if
  import mvm_ctrl_pkg::*;
#(
  parameter int B    = 8,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_reuse;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   in_valid;
  logic [NREQ*B-1:0] in_data;
  logic [NREQ-1:0]   in_ready;
  logic [NREQ-1:0]   out_valid;
  logic [2*B-1:0]    out_data;
  logic              out_last;
  logic [NREQ-1:0]   err;
  logic              core_loadMatrix;
  logic              core_loadVector;
  logic              core_start;
  logic [B-1:0]      core_data_in;
  logic              core_done;
  logic [2*B-1:0]    core_data_out;

  modport master (
    output req, req_reuse, in_valid, in_data, core_done, core_data_out,
    input  gnt, in_ready, out_valid, out_data, out_last, err,
           core_loadMatrix, core_loadVector, core_start, core_data_in
  );

  modport slave (
    input  req, req_reuse, in_valid, in_data, core_done, core_data_out,
    output gnt, in_ready, out_valid, out_data, out_last, err,
           core_loadMatrix, core_loadVector, core_start, core_data_in
  );
endinterface

// File: rtl/mvm_ctrl_rr_arb.sv
// rtl/mvm_ctrl_rr_arb.sv - round-robin arbiter, one-hot grant, priority starts at requester 0
module rr_arb
  import mvm_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_adv,
  output logic [N-1:0] o_gnt
);
  localparam logic [N-1:0] ONE = N'(1);

  // r_mask marks requesters ranked above the last winner; empty mask wraps to the lowest.
  logic [N-1:0] r_mask;
  logic [N-1:0] w_masked;

  assign w_masked = i_req & r_mask;
  assign o_gnt    = (|w_masked) ? (w_masked & (-w_masked)) : (i_req & (-i_req));

  // Move priority to the requesters strictly after the one just granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask <= '1;
    end else if (i_adv && (|i_req)) begin
      r_mask <= ~((o_gnt << 1) - ONE);
    end
  end
endmodule

// File: rtl/mvm_ctrl.sv
// rtl/mvm_ctrl.sv - arbitrated job controller for an MVM core; optional matrix reuse via MVM_CTRL_MATRIX_REUSE_EN
module mvm_ctrl
  import mvm_ctrl_pkg::*;
#(
  parameter int K    = 8,
  parameter int B    = 8,
  parameter int NREQ = 2
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  mvm_ctrl_if.slave bus
);
  localparam int KK  = K * K;
  localparam int TMO = TMO_MULT * KK;
  localparam int CW  = $clog2(TMO);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_started;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_mat_owner;
  logic            r_mat_valid;
  logic [NREQ-1:0] w_arb_gnt;
  logic            w_vld, w_grant, w_reuse, w_load_m, w_load_v;
  logic            w_take, w_tick, w_mat_done, w_abort;
  logic [B-1:0]    w_core_din;

  rr_arb #(.N(NREQ)) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (bus.req),
    .i_adv   (w_grant),
    .o_gnt   (w_arb_gnt)
  );

  assign w_vld = |(bus.in_valid & r_gnt);

`ifdef MVM_CTRL_MATRIX_REUSE_EN
  assign w_reuse = r_mat_valid && (r_mat_owner == w_arb_gnt) && (|(bus.req_reuse & w_arb_gnt));
`else
  logic w_reuse_unused;
  assign w_reuse        = 1'b0;
  assign w_reuse_unused = |{bus.req_reuse, r_mat_owner, r_mat_valid};
`endif

  // Route the granted requester's word to the core; zero when nobody holds the grant.
  always_comb begin
    w_core_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) w_core_din = bus.in_data[i*B +: B];
    end
  end

  assign bus.gnt             = r_gnt;
  assign bus.core_data_in    = w_core_din;
  assign bus.core_loadMatrix = w_load_m;
  assign bus.core_loadVector = w_load_v;

  // Next state and all per-cycle strobes/outputs; load pulse fires on the first valid word, which is not consumed.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant         = 1'b0;
    w_load_m        = 1'b0;
    w_load_v        = 1'b0;
    w_take          = 1'b0;
    w_tick          = 1'b0;
    w_mat_done      = 1'b0;
    w_abort         = 1'b0;
    bus.in_ready    = '0;
    bus.out_valid   = '0;
    bus.out_data    = '0;
    bus.out_last    = 1'b0;
    bus.err         = '0;
    bus.core_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req) begin
          w_grant     = 1'b1;
          w_state_nxt = w_reuse ? ST_LOAD_V : ST_LOAD_M;
        end
      end
      ST_LOAD_M, ST_LOAD_V: begin
        if (!r_started) begin
          if (w_vld) begin
            if (r_state == ST_LOAD_M) w_load_m = 1'b1;
            else                      w_load_v = 1'b1;
          end
        end else if (w_vld) begin
          w_take       = 1'b1;
          bus.in_ready = r_gnt;
          if (r_state == ST_LOAD_M && r_cnt == CW'(KK - 1)) begin
            w_mat_done  = 1'b1;
            w_state_nxt = ST_LOAD_V;
          end else if (r_state == ST_LOAD_V && r_cnt == CW'(K - 1)) begin
            w_state_nxt = ST_START;
          end
        end else begin
          w_abort     = 1'b1;
          bus.err     = r_gnt;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        bus.core_start = 1'b1;
        w_state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.core_done) begin
          w_state_nxt = ST_DRAIN;
        end else if (r_cnt == CW'(TMO - 1)) begin
          w_abort     = 1'b1;
          bus.err     = r_gnt;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tick = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_tick        = 1'b1;
        bus.out_valid = r_gnt;
        bus.out_data  = bus.core_data_out;
        if (r_cnt == CW'(K - 1)) begin
          bus.out_last = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Word/cycle counter, load-started flag, held grant and stored-matrix bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_started   <= 1'b0;
      r_gnt       <= '0;
      r_mat_valid <= 1'b0;
      r_mat_owner <= '0;
    end else begin
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (w_take || w_tick)  r_cnt <= r_cnt + CW'(1);

      if (w_state_nxt != r_state)   r_started <= 1'b0;
      else if (w_load_m || w_load_v) r_started <= 1'b1;

      if (w_grant)                     r_gnt <= w_arb_gnt;
      else if (w_state_nxt == ST_IDLE) r_gnt <= '0;

      if (w_load_m || w_abort) begin
        r_mat_valid <= 1'b0;
      end else if (w_mat_done) begin
        r_mat_valid <= 1'b1;
        r_mat_owner <= r_gnt;
      end
    end
  end
endmodule

// File: tb/tb_mvm_ctrl.sv
// tb/tb_mvm_ctrl.sv - scoreboard bench for mvm_ctrl (K=8, B=8, NREQ=2)
module tb_mvm_ctrl;
  localparam int K = 8;
  localparam int B = 8;
  localparam int NREQ = 2;
  localparam int EV_GNT = 0, EV_LDM = 1, EV_LDV = 2, EV_START = 3, EV_TAKE = 4, EV_OUT = 5, EV_ERR = 6;
`ifdef MVM_CTRL_MATRIX_REUSE_EN
  localparam bit REUSE_ON = 1'b1;
`else
  localparam bit REUSE_ON = 1'b0;
`endif

  typedef struct {
    int kind;
    int idx;
    int data;
    bit last;
    int dly;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  ev_t exp_q[$];
  logic [NREQ-1:0] prev_gnt = '0;

  mvm_ctrl_if #(.B(B), .NREQ(NREQ)) bus();

  mvm_ctrl #(.K(K), .B(B), .NREQ(NREQ)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Row r of the 1..64 ramp summed against a constant vector xv: xv*(64r+36).
  function automatic int y_of(input int row, input int xv);
    return xv * (64 * row + 36);
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic push(input int kind, input int idx, input int data, input bit last, input int dly);
    ev_t e;
    e.kind = kind; e.idx = idx; e.data = data; e.last = last; e.dly = dly;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int idx, input int data, input bit last);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d idx=%0d data=%0d, required no event", kind, idx, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.idx != idx || e.data != data || e.last != last ||
          (e.dly >= 0 && cyc - last_cyc != e.dly)) begin
        n_bad++;
        $display("FAIL event: got kind=%0d idx=%0d data=%0d last=%0d dly=%0d, required kind=%0d idx=%0d data=%0d last=%0d dly=%0d",
                 kind, idx, data, last, cyc - last_cyc, e.kind, e.idx, e.data, e.last, e.dly);
      end
    end
    last_cyc = cyc;
  endtask

  // Monitor: turn every DUT-visible event into a scoreboard pop.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      if (bus.gnt != prev_gnt && bus.gnt != '0) observe(EV_GNT, oh_idx(bus.gnt), 0, 1'b0);
      if (bus.core_loadMatrix) observe(EV_LDM, 0, 0, 1'b0);
      if (bus.core_loadVector) observe(EV_LDV, 0, 0, 1'b0);
      if (bus.core_start) observe(EV_START, 0, 0, 1'b0);
      if (|(bus.in_ready & bus.in_valid)) observe(EV_TAKE, oh_idx(bus.in_ready), int'(bus.core_data_in), 1'b0);
      if (|bus.out_valid) observe(EV_OUT, oh_idx(bus.out_valid), int'(bus.out_data), bus.out_last);
      if (|bus.err) observe(EV_ERR, oh_idx(bus.err), 0, 1'b0);
      n_total++;
      if (!$onehot0(bus.gnt)) begin
        n_bad++;
        $display("FAIL gnt_onehot: gnt=%b required at most one bit", bus.gnt);
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic check_zero(input string name);
    logic [4*NREQ+4+3*B-1:0] v;
    v = {bus.gnt, bus.in_ready, bus.out_valid, bus.err, bus.out_last, bus.core_loadMatrix,
         bus.core_loadVector, bus.core_start, bus.out_data, bus.core_data_in};
    n_total++;
    if (v != '0) begin
      n_bad++;
      $display("FAIL %s: outputs=%h required 0", name, v);
    end
  endtask

  task automatic run_job(input int r, input bit reuse, input bit exp_ldm, input int drop_at,
                         input bit no_done, input int rst_beat, input int xv, input bit keep);
    bit got;
    int lim;
    push(EV_GNT, r, 0, 1'b0, -1);
    if (exp_ldm) begin
      push(EV_LDM, 0, 0, 1'b0, 0);
      lim = (drop_at >= 0) ? drop_at : K * K;
      for (int i = 0; i < lim; i++) push(EV_TAKE, r, i + 1, 1'b0, 1);
      if (drop_at >= 0) push(EV_ERR, r, 0, 1'b0, 1);
    end
    if (drop_at < 0) begin
      push(EV_LDV, 0, 0, 1'b0, exp_ldm ? 1 : 0);
      for (int j = 0; j < K; j++) push(EV_TAKE, r, xv, 1'b0, 1);
      push(EV_START, 0, 0, 1'b0, 1);
      if (no_done) push(EV_ERR, r, 0, 1'b0, 4 * K * K);
      else for (int j = 0; j < K; j++) push(EV_OUT, r, y_of(j, xv), j == K - 1, (j == 0) ? 5 : 1);
    end

    bus.req_reuse[r] = reuse;
    bus.req[r] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(posedge clk); #1;
      got = bus.gnt[r];
    end
    n_total++;
    if (!got) begin
      n_bad++;
      $display("FAIL gnt_wait: gnt[%0d]=0 required 1", r);
      exp_q.delete();
      bus.req = '0;
      bus.req_reuse = '0;
      return;
    end
    if (!keep) bus.req = '0;
    bus.req_reuse[r] = 1'b0;
    bus.in_valid[r] = 1'b1;
    bus.in_data[r*B +: B] = 8'h5A;
    if (exp_ldm) begin
      for (int i = 0; i < K * K; i++) begin
        @(posedge clk); #1;
        if (i == drop_at) begin
          bus.in_valid[r] = 1'b0;
          bus.in_data = '0;
          @(posedge clk); #1;
          return;
        end
        bus.in_data[r*B +: B] = B'(i + 1);
      end
      @(posedge clk); #1;
      bus.in_data[r*B +: B] = 8'h5A;
    end
    for (int j = 0; j < K; j++) begin
      @(posedge clk); #1;
      bus.in_data[r*B +: B] = B'(xv);
    end
    @(posedge clk); #1;
    bus.in_valid[r] = 1'b0;
    bus.in_data = '0;
    if (no_done) begin
      repeat (4 * K * K + 1) begin @(posedge clk); #1; end
      return;
    end
    repeat (3) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bus.core_done = 1'b1;
    for (int j = 0; j < K; j++) begin
      @(posedge clk); #1;
      bus.core_done = 1'b0;
      bus.core_data_out = 16'(y_of(j, xv));
      if (j == rst_beat) begin
        bus.in_data = {NREQ{8'h77}};
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_drain");
        exp_q.delete();
        bus.core_data_out = '0;
        bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    bus.core_data_out = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 2'b01;
    bus.req_reuse = '0;
    bus.in_valid = 2'b01;
    bus.in_data = {NREQ{8'h77}};
    bus.core_done = 1'b0;
    bus.core_data_out = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    bus.req = '0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.core_data_out = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ramp matrix, unit vector, requester 0 alone
    run_job(0, 1'b0, 1'b1, -1, 1'b0, -1, 1, 1'b0);
    // same owner asks for reuse
    run_job(0, 1'b1, !REUSE_ON, -1, 1'b0, -1, 2, 1'b0);
    // both requesting continuously: pointer sits after 0, so 1,0,1,0
    bus.req = 2'b11;
    run_job(1, 1'b0, 1'b1, -1, 1'b0, -1, 1, 1'b1);
    run_job(0, 1'b0, 1'b1, -1, 1'b0, -1, 2, 1'b1);
    run_job(1, 1'b0, 1'b1, -1, 1'b0, -1, 1, 1'b1);
    run_job(0, 1'b0, 1'b1, -1, 1'b0, -1, 2, 1'b0);
    // stream gap at matrix word 30
    run_job(1, 1'b0, 1'b1, 30, 1'b0, -1, 1, 1'b0);
    // core never completes
    run_job(0, 1'b0, 1'b1, -1, 1'b1, -1, 1, 1'b0);
    // reset in the middle of drain, then a clean job from requester 1
    run_job(0, 1'b0, 1'b1, -1, 1'b0, 3, 1, 1'b0);
    run_job(1, 1'b0, 1'b1, -1, 1'b0, -1, 2, 1'b0);
    // reuse asked by a requester that does not own the stored matrix
    run_job(0, 1'b1, 1'b1, -1, 1'b0, -1, 1, 1'b0);
    // now owner 0 asks again
    run_job(0, 1'b1, !REUSE_ON, -1, 1'b0, -1, 2, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: pending=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
